// File: rtl/mem_port_arbiter_if.sv
// Core/memory bus bundle for mem_port_arbiter.
// slave: arbiter side; master: core + memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              inst_ren;
  logic [ADDR_W-1:0] inst_addr;
  logic [31:0]       inst_data;
  logic              inst_stall;
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_dout;
  logic [31:0]       mem_din;
  logic              data_stall;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;
  logic              bus_timeout;

  modport slave (
    input  inst_ren, inst_addr,
    input  mem_ren, mem_wen, mem_addr, mem_dout,
    input  bus_ack, bus_rdata,
    output inst_data, inst_stall,
    output mem_din, data_stall,
    output bus_req, bus_we, bus_addr, bus_wdata,
    output bus_timeout
  );

  modport master (
    output inst_ren, inst_addr,
    output mem_ren, mem_wen, mem_addr, mem_dout,
    output bus_ack, bus_rdata,
    input  inst_data, inst_stall,
    input  mem_din, data_stall,
    input  bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_timeout
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between inst fetch and data ports.
// Ports: clk, rst (async high), port_if (slave):
//   inst_* / mem_* core side with stalls, bus_* memory side.
// Params: TIMEOUT (0 = no watchdog), ADDR_W.
// Option: ARB_ROUND_ROBIN_EN alternates grants on contention.
module mem_port_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave port_if
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    BUS_I,
    BUS_D,
    DONE_I,
    DONE_D
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              bus_req_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [31:0]       bus_wdata_q;
  logic              bus_to_q;
  logic [31:0]       inst_data_q;
  logic [31:0]       mem_din_q;

  logic        want_d;
  logic        want_i;
  logic        pick_d;
  logic        expire;
  logic [31:0] rd_val;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = data port was granted last
  logic last_q;
`endif

  always_comb begin
    want_d = port_if.mem_ren | port_if.mem_wen;
    want_i = port_if.inst_ren;
`ifdef ARB_ROUND_ROBIN_EN
    pick_d = want_d & (~want_i | ~last_q);
`else
    pick_d = want_d;
`endif
    expire = (TIMEOUT > 0) && (cnt_q == CNT_MAX);
    // an abort returns zero as read data
    rd_val = port_if.bus_ack ? port_if.bus_rdata : 32'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_to_q    <= 1'b0;
      inst_data_q <= '0;
      mem_din_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= 1'b0;
`endif
    end else begin
      bus_to_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE_I, DONE_D: begin
          bus_req_q <= 1'b0;
          bus_we_q  <= 1'b0;
          state_q   <= IDLE;
          if (want_d || want_i) begin
            bus_req_q <= 1'b1;
            cnt_q     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q    <= pick_d;
`endif
            if (pick_d) begin
              state_q     <= BUS_D;
              bus_we_q    <= port_if.mem_wen;
              bus_addr_q  <= port_if.mem_addr;
              bus_wdata_q <= port_if.mem_dout;
            end else begin
              state_q    <= BUS_I;
              bus_addr_q <= port_if.inst_addr;
            end
          end
        end
        BUS_I, BUS_D: begin
          if (port_if.bus_ack || expire) begin
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            bus_to_q  <= ~port_if.bus_ack;
            if (state_q == BUS_I) begin
              state_q     <= DONE_I;
              inst_data_q <= rd_val;
            end else begin
              state_q <= DONE_D;
              if (!bus_we_q) mem_din_q <= rd_val;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign port_if.inst_stall  = want_i & (state_q != DONE_I);
  assign port_if.data_stall  = want_d & (state_q != DONE_D);
  assign port_if.inst_data   = inst_data_q;
  assign port_if.mem_din     = mem_din_q;
  assign port_if.bus_req     = bus_req_q;
  assign port_if.bus_we      = bus_we_q;
  assign port_if.bus_addr    = bus_addr_q;
  assign port_if.bus_wdata   = bus_wdata_q;
  assign port_if.bus_timeout = bus_to_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with memory responder
// and a scoreboard of expected per-port results.
module tb_mem_port_arbiter;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW)) port_if ();

  mem_port_arbiter #(
    .TIMEOUT(16),
    .ADDR_W (AW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .port_if(port_if)
  );

  typedef struct {
    bit          d;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gnt_t;

  exp_t exp_q[$];
  gnt_t glog[$];

  int tests = 0;
  int fails = 0;
  int ack_delay = 0;
  int rcnt = 0;
  logic [31:0] gaddr;
  bit addr_bad = 1'b0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    case (a)
      32'h100: rd = 32'h2402000A;
      32'h104: rd = 32'h8C430004;
      32'h300: rd = 32'hCAFEF00D;
      default: rd = a ^ 32'hA5A5A5A5;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // memory model: ack after ack_delay BUS cycles (-1 = never)
  always @(negedge clk) begin
    if (rst || port_if.bus_req !== 1'b1) begin
      port_if.bus_ack   = 1'b0;
      port_if.bus_rdata = 32'h0;
      rcnt = 0;
    end else begin
      if (rcnt == 0) begin
        glog.push_back('{port_if.bus_we, port_if.bus_addr,
                         port_if.bus_wdata});
        gaddr = port_if.bus_addr;
      end else if (port_if.bus_addr !== gaddr) begin
        addr_bad = 1'b1;
      end
      port_if.bus_ack   = (rcnt == ack_delay);
      port_if.bus_rdata = port_if.bus_ack ? rd(port_if.bus_addr)
                                          : 32'hDEADBEEF;
      rcnt++;
    end
  end

  // counts stalled cycles until the port's stall drops,
  // then checks the result and retires the request
  task automatic wait_port(input bit d, output int n);
    bit   done;
    exp_t e;
    done = 1'b0;
    n = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      #1;
      if ((d ? port_if.data_stall : port_if.inst_stall) === 1'b0)
        done = 1'b1;
      else begin
        n++;
        @(negedge clk);
      end
    end
    chk(d ? "d_done" : "i_done", done, 1);
    if (done) begin
      chk("sb_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_port", d, e.d);
        chk(d ? "mem_din" : "inst_data",
            d ? port_if.mem_din : port_if.inst_data, e.data);
      end
      if (d) begin
        port_if.mem_ren = 1'b0;
        port_if.mem_wen = 1'b0;
      end else begin
        port_if.inst_ren = 1'b0;
      end
    end
  endtask

  initial begin
    int n;
    logic [31:0] ga [4];
    rst = 1'b1;
    port_if.inst_ren  = 1'b0;
    port_if.inst_addr = '0;
    port_if.mem_ren   = 1'b0;
    port_if.mem_wen   = 1'b0;
    port_if.mem_addr  = '0;
    port_if.mem_dout  = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_bus_req", port_if.bus_req, 0);
    chk("rst_bus_addr", port_if.bus_addr, 0);
    chk("rst_inst_data", port_if.inst_data, 0);
    chk("rst_mem_din", port_if.mem_din, 0);
    chk("rst_timeout", port_if.bus_timeout, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // single instruction read, ack on first BUS cycle
    glog.delete();
    port_if.inst_ren  = 1'b1;
    port_if.inst_addr = 32'h100;
    ack_delay = 0;
    exp_q.push_back('{1'b0, 32'h2402000A});
    wait_port(1'b0, n);
    chk("t1_stall_cycles", n, 2);
    chk("t1_grants", glog.size(), 1);
    if (glog.size() >= 1) begin
      chk("t1_addr", glog[0].addr, 32'h100);
      chk("t1_we", glog[0].we, 0);
    end
    @(negedge clk);

    // contention: data write first, then inst, no bubble
    glog.delete();
    port_if.inst_ren  = 1'b1;
    port_if.inst_addr = 32'h104;
    port_if.mem_wen   = 1'b1;
    port_if.mem_addr  = 32'h200;
    port_if.mem_dout  = 32'h55;
    exp_q.push_back('{1'b1, 32'h0});
    exp_q.push_back('{1'b0, 32'h8C430004});
    wait_port(1'b1, n);
    chk("t2_d_cycles", n, 2);
    wait_port(1'b0, n);
    chk("t2_i_extra", n, 2);
    chk("t2_grants", glog.size(), 2);
    if (glog.size() >= 2) begin
      chk("t2_g0_we", glog[0].we, 1);
      chk("t2_g0_addr", glog[0].addr, 32'h200);
      chk("t2_g0_wdata", glog[0].wdata, 32'h55);
      chk("t2_g1_we", glog[1].we, 0);
      chk("t2_g1_addr", glog[1].addr, 32'h104);
    end
    @(negedge clk);

    // delayed ack: five BUS cycles
    addr_bad = 1'b0;
    port_if.mem_ren  = 1'b1;
    port_if.mem_addr = 32'h300;
    ack_delay = 4;
    exp_q.push_back('{1'b1, 32'hCAFEF00D});
    wait_port(1'b1, n);
    chk("t3_stall_cycles", n, 6);
    chk("t3_addr_stable", addr_bad, 0);
    @(negedge clk);

    // watchdog abort
    port_if.mem_ren  = 1'b1;
    port_if.mem_addr = 32'h304;
    ack_delay = -1;
    exp_q.push_back('{1'b1, 32'h0});
    wait_port(1'b1, n);
    chk("t4_stall_cycles", n, 17);
    chk("t4_timeout_pulse", port_if.bus_timeout, 1);
    chk("t4_req_dropped", port_if.bus_req, 0);
    @(negedge clk);
    #1;
    chk("t4_pulse_end", port_if.bus_timeout, 0);
    @(negedge clk);
    port_if.inst_ren  = 1'b1;
    port_if.inst_addr = 32'h100;
    ack_delay = 0;
    exp_q.push_back('{1'b0, 32'h2402000A});
    wait_port(1'b0, n);
    chk("t4_next_cycles", n, 2);
    @(negedge clk);

    // ack in the expiry cycle wins
    port_if.mem_ren  = 1'b1;
    port_if.mem_addr = 32'h300;
    ack_delay = 15;
    exp_q.push_back('{1'b1, 32'hCAFEF00D});
    wait_port(1'b1, n);
    chk("t4b_stall_cycles", n, 17);
    chk("t4b_no_timeout", port_if.bus_timeout, 0);
    @(negedge clk);
    #1;
    chk("t4b_no_timeout2", port_if.bus_timeout, 0);
    @(negedge clk);

    // async reset during BUS_D
    port_if.mem_wen  = 1'b1;
    port_if.mem_addr = 32'h400;
    port_if.mem_dout = 32'h77;
    ack_delay = -1;
    @(negedge clk);
    #1;
    chk("t5_req_before", port_if.bus_req, 1);
    chk("t5_we_before", port_if.bus_we, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_req_rst", port_if.bus_req, 0);
    chk("t5_we_rst", port_if.bus_we, 0);
    chk("t5_addr_rst", port_if.bus_addr, 0);
    chk("t5_wdata_rst", port_if.bus_wdata, 0);
    chk("t5_inst_data_rst", port_if.inst_data, 0);
    chk("t5_mem_din_rst", port_if.mem_din, 0);
    chk("t5_timeout_rst", port_if.bus_timeout, 0);
    port_if.mem_wen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_dstall_idle", port_if.data_stall, 0);
    @(negedge clk);
    port_if.inst_ren  = 1'b1;
    port_if.inst_addr = 32'h104;
    ack_delay = 0;
    exp_q.push_back('{1'b0, 32'h8C430004});
    wait_port(1'b0, n);
    chk("t5_after_cycles", n, 2);
    @(negedge clk);

    // continuous contention: grant order
    glog.delete();
    port_if.inst_ren  = 1'b1;
    port_if.inst_addr = 32'h100;
    port_if.mem_ren   = 1'b1;
    port_if.mem_addr  = 32'h300;
    ack_delay = 0;
`ifdef ARB_ROUND_ROBIN_EN
    ga = '{32'h300, 32'h100, 32'h300, 32'h100};
`else
    ga = '{32'h300, 32'h300, 32'h300, 32'h300};
`endif
    repeat (9) @(negedge clk);
    port_if.inst_ren = 1'b0;
    port_if.mem_ren  = 1'b0;
    chk("t6_grant_count", glog.size() >= 4, 1);
    for (int i = 0; i < 4; i++)
      if (i < glog.size())
        chk($sformatf("t6_grant%0d", i), glog[i].addr, ga[i]);
    repeat (3) @(negedge clk);
    #1;
    chk("t6_idle_req", port_if.bus_req, 0);
    chk("t6_sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
